// File: rtl/m72_pkg.sv
// Shared constants, types and width helpers for the M72 sound-subsystem mailbox.
package m72_pkg;

    localparam logic [7:0] MBOX_FILL   = 8'hFF;
    localparam int         MBOX_MAX_CH = 4;

    typedef struct packed {
        logic [MBOX_MAX_CH-1:0] overflow;
        logic [MBOX_MAX_CH-1:0] nonempty;
    } mbox_status_t;

    // Index width clamped to 1 bit so single-channel / single-entry builds still elaborate.
    function automatic int mbox_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int mbox_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int mbox_tmr_w(input int len);
        return (len > 0) ? $clog2(len + 1) : 1;
    endfunction

endpackage

// File: rtl/snd_mailbox_fifo.sv
// Single command FIFO: storage, wrap-around pointers and occupancy count.
module snd_mailbox_fifo
    import m72_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int PW = mbox_idx_w(DEPTH);
    localparam int CW = mbox_cnt_w(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot the same cycle, so the push is accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/snd_mailbox.sv
// Main-CPU to sound-CPU command mailbox: per-channel FIFOs, INT/NMI generation, reply latch.
module snd_mailbox
    import m72_pkg::*;
#(
    parameter int                NUM_CH   = 2,
    parameter int                DEPTH    = 4,
    parameter int                DW       = 8,
    parameter logic [NUM_CH-1:0] INT_MASK = 'b01,
    parameter int                NMI_CH   = 1,
    parameter int                NMI_LEN  = 16,
    parameter logic [DW-1:0]     FILL     = DW'(MBOX_FILL)
) (
    input  logic                          CLK_32M,
    input  logic                          reset_n,
    input  logic                          pause,
    input  logic                          cmd_wr,
    input  logic [mbox_idx_w(NUM_CH)-1:0] cmd_ch,
    input  logic [DW-1:0]                 cmd_data,
    input  logic                          snd_rd,
    input  logic [mbox_idx_w(NUM_CH)-1:0] snd_ch,
    output logic [DW-1:0]                 snd_dout,
    output logic [2*NUM_CH-1:0]           snd_status,
    input  logic                          snd_clr_ovf,
    output logic                          snd_int_n,
    output logic                          snd_nmi_n,
    input  logic                          rep_wr,
    input  logic [DW-1:0]                 rep_data,
    input  logic                          main_rd,
    output logic [DW-1:0]                 main_dout,
    output logic                          main_irq
);

    localparam int IW = mbox_idx_w(NUM_CH);
    localparam int TW = mbox_tmr_w(NMI_LEN);

    logic [NUM_CH-1:0] push, pop, full, empty, nonempty;
    logic [DW-1:0]     head [NUM_CH];

    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [DW-1:0]     snd_dout_q, snd_dout_d;
    logic [DW-1:0]     main_dout_q, main_dout_d;
    logic              main_irq_q, main_irq_d;
    logic              nmi_active;

    // Out-of-range channel indices match no generate slot and are therefore ignored.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign push[i] = cmd_wr && (cmd_ch == IW'(i));
        assign pop[i]  = snd_rd && (snd_ch == IW'(i));

        snd_mailbox_fifo #(
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_fifo (
            .clk       (CLK_32M),
            .rst_n     (reset_n),
            .push      (push[i]),
            .push_data (cmd_data),
            .pop       (pop[i]),
            .full      (full[i]),
            .empty     (empty[i]),
            .head      (head[i])
        );
    end

    assign nonempty = ~empty;

    always_comb begin
        snd_dout_d = snd_dout_q;
        if (|pop) begin
            snd_dout_d = FILL;
            for (int i = 0; i < NUM_CH; i++) begin
                if (pop[i] && !empty[i]) snd_dout_d = head[i];
            end
        end
    end

    // Set term is OR-ed after the clear so a coincident overflow survives snd_clr_ovf.
    assign ovf_d = (ovf_q & ~{NUM_CH{snd_clr_ovf}}) | (push & full & ~pop);

    always_comb begin
        main_dout_d = main_dout_q;
        main_irq_d  = main_irq_q;
        if (rep_wr) begin
            main_dout_d = rep_data;
            main_irq_d  = 1'b1;
        end else if (main_rd) begin
            main_irq_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q       <= '0;
            snd_dout_q  <= FILL;
            main_dout_q <= '0;
            main_irq_q  <= 1'b0;
        end else begin
            ovf_q       <= ovf_d;
            snd_dout_q  <= snd_dout_d;
            main_dout_q <= main_dout_d;
            main_irq_q  <= main_irq_d;
        end
    end

    if (NMI_CH < NUM_CH) begin : g_nmi
        logic          ne_prev_q;
        logic          nmi_trig;
        logic [TW-1:0] nmi_cnt_q, nmi_cnt_d;

        assign nmi_trig = nonempty[NMI_CH] & ~ne_prev_q;

        // Retrigger reloads the full length; paused cycles hold the count.
        always_comb begin
            nmi_cnt_d = nmi_cnt_q;
            if (nmi_trig) begin
                nmi_cnt_d = TW'(NMI_LEN);
            end else if ((nmi_cnt_q != '0) && !pause) begin
                nmi_cnt_d = nmi_cnt_q - TW'(1);
            end
        end

        always_ff @(posedge CLK_32M or negedge reset_n) begin
            if (!reset_n) begin
                ne_prev_q <= 1'b0;
                nmi_cnt_q <= '0;
            end else begin
                ne_prev_q <= nonempty[NMI_CH];
                nmi_cnt_q <= nmi_cnt_d;
            end
        end

        assign nmi_active = (nmi_cnt_q != '0);
    end else begin : g_no_nmi
        assign nmi_active = 1'b0;
    end

    assign snd_dout   = snd_dout_q;
    assign snd_status = {ovf_q, nonempty};
    assign snd_int_n  = ~|(nonempty & INT_MASK);
    assign snd_nmi_n  = ~nmi_active;
    assign main_dout  = main_dout_q;
    assign main_irq   = main_irq_q;

endmodule

// File: tb/tb_snd_mailbox.sv
// Self-checking bench for snd_mailbox: directed scenarios plus random traffic against a queue model.
module tb_snd_mailbox;

    localparam int         NUM_CH   = 2;
    localparam int         DEPTH    = 4;
    localparam int         DW       = 8;
    localparam logic [1:0] INT_MASK = 2'b01;
    localparam int         NMI_CH   = 1;
    localparam int         NMI_LEN  = 16;
    localparam logic [7:0] FILL     = 8'hFF;

    logic       CLK_32M = 1'b0;
    logic       reset_n = 1'b0;
    logic       pause = 1'b0, cmd_wr = 1'b0, snd_rd = 1'b0, snd_clr_ovf = 1'b0;
    logic       rep_wr = 1'b0, main_rd = 1'b0;
    logic [0:0] cmd_ch = '0, snd_ch = '0;
    logic [7:0] cmd_data = '0, rep_data = '0;
    logic [7:0] snd_dout, main_dout;
    logic [3:0] snd_status;
    logic       snd_int_n, snd_nmi_n, main_irq;

    snd_mailbox #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DW(DW), .INT_MASK(INT_MASK),
        .NMI_CH(NMI_CH), .NMI_LEN(NMI_LEN), .FILL(FILL)
    ) dut (
        .CLK_32M(CLK_32M), .reset_n(reset_n), .pause(pause),
        .cmd_wr(cmd_wr), .cmd_ch(cmd_ch), .cmd_data(cmd_data),
        .snd_rd(snd_rd), .snd_ch(snd_ch), .snd_dout(snd_dout),
        .snd_status(snd_status), .snd_clr_ovf(snd_clr_ovf),
        .snd_int_n(snd_int_n), .snd_nmi_n(snd_nmi_n),
        .rep_wr(rep_wr), .rep_data(rep_data), .main_rd(main_rd),
        .main_dout(main_dout), .main_irq(main_irq)
    );

    always #5 CLK_32M = ~CLK_32M;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one queue per channel plus plain bookkeeping values.
    logic [7:0]  mq [NUM_CH][$];
    logic [1:0]  m_ovf;
    logic [7:0]  m_dout, m_main_dout;
    logic        m_irq, m_prev_ne;
    int          m_rem;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) mq[i].delete();
        m_ovf       = '0;
        m_dout      = FILL;
        m_main_dout = '0;
        m_irq       = 1'b0;
        m_prev_ne   = 1'b0;
        m_rem       = 0;
    endtask

    // Applies one clock edge's worth of the mailbox rules to the model.
    task automatic model_edge();
        int ch;
        logic ne_now;
        ne_now = (mq[NMI_CH].size() != 0);
        if (ne_now && !m_prev_ne)   m_rem = NMI_LEN;
        else if (m_rem > 0 && !pause) m_rem--;
        m_prev_ne = ne_now;

        if (rep_wr) begin
            m_main_dout = rep_data;
            m_irq       = 1'b1;
        end else if (main_rd) begin
            m_irq = 1'b0;
        end

        if (snd_rd) begin
            ch = int'(snd_ch);
            if (mq[ch].size() == 0) m_dout = FILL;
            else                    m_dout = mq[ch].pop_front();
        end

        if (snd_clr_ovf) m_ovf = '0;

        if (cmd_wr) begin
            ch = int'(cmd_ch);
            if (mq[ch].size() < DEPTH) mq[ch].push_back(cmd_data);
            else                       m_ovf[ch] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [1:0] ne;
        for (int i = 0; i < NUM_CH; i++) ne[i] = (mq[i].size() != 0);
        check("snd_dout",   32'(snd_dout),   32'(m_dout));
        check("snd_status", 32'(snd_status), 32'({m_ovf, ne}));
        check("snd_int_n",  32'(snd_int_n),  32'(~|(ne & INT_MASK)));
        check("snd_nmi_n",  32'(snd_nmi_n),  32'(m_rem == 0));
        check("main_dout",  32'(main_dout),  32'(m_main_dout));
        check("main_irq",   32'(main_irq),   32'(m_irq));
    endtask

    task automatic step();
        @(posedge CLK_32M);
        model_edge();
        #1;
        check_all();
        cmd_wr      = 1'b0;
        snd_rd      = 1'b0;
        snd_clr_ovf = 1'b0;
        rep_wr      = 1'b0;
        main_rd     = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [7:0] d);
        cmd_wr   = 1'b1;
        cmd_ch   = 1'(ch);
        cmd_data = d;
    endtask

    task automatic rd(input int ch);
        snd_rd = 1'b1;
        snd_ch = 1'(ch);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic measure_nmi(input int pause_from, input int pause_to, output int len);
        logic seen;
        len  = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            pause = (i >= pause_from) && (i < pause_to);
            step();
            if (!snd_nmi_n) begin
                len++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        pause = 1'b0;
    endtask

    initial begin
        int len;
        model_reset();
        #12;
        check_all();
        check("rst_snd_dout", 32'(snd_dout), 32'h0000_00FF);
        @(negedge CLK_32M);
        reset_n = 1'b1;

        // Two commands on ch0, popped in order with one-cycle latency.
        wr(0, 8'h12); step();
        check("t1_int_after_wr", 32'(snd_int_n), 32'h0);
        wr(0, 8'h34); step();
        rd(0); step();
        check("t1_pop_12", 32'(snd_dout), 32'h12);
        rd(0); step();
        check("t1_pop_34", 32'(snd_dout), 32'h34);
        check("t1_int_idle", 32'(snd_int_n), 32'h1);

        // Overflow on ch1, drain to FILL, clear sticky flag.
        for (int i = 1; i <= 5; i++) begin
            wr(1, 8'(i)); step();
        end
        check("t2_ovf_set", 32'(snd_status[3]), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            rd(1); step();
            check("t2_pop", 32'(snd_dout), (i <= 4) ? 32'(i) : 32'hFF);
        end
        check("t2_ovf_sticky", 32'(snd_status[3]), 32'h1);
        snd_clr_ovf = 1'b1; step();
        check("t2_ovf_clr", 32'(snd_status[3]), 32'h0);
        idle(20);

        // NMI pulse length, plain and with pause held for five cycles.
        wr(1, 8'hAA); step();
        measure_nmi(0, 0, len);
        check("t3_nmi_len", 32'(len), 32'd16);
        rd(1); step();
        idle(4);
        wr(1, 8'hAA); step();
        measure_nmi(3, 8, len);
        check("t3_nmi_len_pause", 32'(len), 32'd21);
        rd(1); step();
        idle(4);

        // Full ch0 with simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            wr(0, 8'h41 + 8'(i)); step();
        end
        wr(0, 8'h77); rd(0); step();
        check("t4_pop_oldest", 32'(snd_dout), 32'h41);
        check("t4_no_ovf", 32'(snd_status[2]), 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(0); step();
        end
        check("t4_last_77", 32'(snd_dout), 32'h77);

        // Reply latch.
        rep_wr = 1'b1; rep_data = 8'h5C; step();
        check("t5_irq_set", 32'(main_irq), 32'h1);
        check("t5_dout_5c", 32'(main_dout), 32'h5C);
        rep_wr = 1'b1; rep_data = 8'h5D; main_rd = 1'b1; step();
        check("t5_irq_wr_wins", 32'(main_irq), 32'h1);
        check("t5_dout_5d", 32'(main_dout), 32'h5D);
        main_rd = 1'b1; step();
        check("t5_irq_clr", 32'(main_irq), 32'h0);
        check("t5_dout_kept", 32'(main_dout), 32'h5D);

        // Asynchronous reset in the middle of an NMI pulse with data queued.
        wr(0, 8'h99); step();
        wr(1, 8'h55); step();
        rep_wr = 1'b1; rep_data = 8'h11; step();
        idle(2);
        check("t6_nmi_active", 32'(snd_nmi_n), 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("t6_nmi_cleared", 32'(snd_nmi_n), 32'h1);
        check("t6_status_cleared", 32'(snd_status), 32'h0);
        @(negedge CLK_32M);
        reset_n = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cmd_wr      = ($urandom_range(0, 99) < 45);
            cmd_ch      = 1'($urandom_range(0, 1));
            cmd_data    = 8'($urandom);
            snd_rd      = ($urandom_range(0, 99) < 40);
            snd_ch      = 1'($urandom_range(0, 1));
            snd_clr_ovf = ($urandom_range(0, 99) < 5);
            rep_wr      = ($urandom_range(0, 99) < 20);
            rep_data    = 8'($urandom);
            main_rd     = ($urandom_range(0, 99) < 20);
            pause       = ($urandom_range(0, 99) < 15);
            step();
        end
        pause = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
